// File: rtl/riscv_bus_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : riscv_bus_pkg
//  Description : Shared types and default widths for the fetch/data bus
//                arbiter (FSM states, bus owner, starve counter width).
//  Revision    : 1.0 - initial release
// ============================================================================
package riscv_bus_pkg;

  localparam int unsigned DEF_ADDR_W   = 32;
  localparam int unsigned DEF_DATA_W   = 32;
  localparam int unsigned STARVE_CNT_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RESP = 2'd2
  } bus_state_e;

  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_DM = 1'b1
  } bus_owner_e;

endpackage
`default_nettype wire

// File: rtl/riscv_bus_prio.sv
`default_nettype none
// ============================================================================
//  Module      : riscv_bus_prio
//  Description : Winner selection for the bus arbiter. Data wins by default;
//                after STARVE_MAX data grants taken while fetch waits, fetch
//                wins once so it always makes forward progress.
//  Revision    : 1.0 - initial release
// ============================================================================
module riscv_bus_prio
  import riscv_bus_pkg::*;
#(
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_if_req,
  input  logic       i_dm_req,
  input  logic       i_decide,
  output bus_owner_e o_winner
);

  localparam logic [STARVE_CNT_W-1:0] C_STARVE_MAX = STARVE_CNT_W'(STARVE_MAX);
  localparam logic [STARVE_CNT_W-1:0] C_CNT_ONE    = STARVE_CNT_W'(1);

  logic [STARVE_CNT_W-1:0] starve_cnt_q;
  logic [STARVE_CNT_W-1:0] starve_cnt_d;
  logic                    w_starved;

  assign w_starved = (starve_cnt_q == C_STARVE_MAX);

  // Fetch wins when data is absent or fetch has been starved long enough
  always_comb begin
    o_winner = OWN_IF;
    if (i_if_req && (!i_dm_req || w_starved)) begin
      o_winner = OWN_IF;
    end else if (i_dm_req) begin
      o_winner = OWN_DM;
    end
  end

  // Count data grants that overtook a waiting fetch; anything else clears it
  always_comb begin
    starve_cnt_d = starve_cnt_q;
    if (i_decide) begin
      if ((o_winner == OWN_DM) && i_if_req) begin
        if (starve_cnt_q < C_STARVE_MAX) begin
          starve_cnt_d = starve_cnt_q + C_CNT_ONE;
        end
      end else begin
        starve_cnt_d = '0;
      end
    end
  end

  // Starve counter register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      starve_cnt_q <= '0;
    end else begin
      starve_cnt_q <= starve_cnt_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/riscv_bus_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : riscv_bus_arbiter
//  Description : Shares the single memory bus between the fetch stage and the
//                data/MEM stage. One outstanding access at a time, responses
//                routed to the owner, and a MEM-stage stall for the hazard
//                unit. A late/unexpected bus response raises a sticky error.
//  Revision    : 1.0 - initial release
// ============================================================================
module riscv_bus_arbiter
  import riscv_bus_pkg::*;
#(
  parameter int unsigned ADDR_W     = DEF_ADDR_W,
  parameter int unsigned DATA_W     = DEF_DATA_W,
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  // fetch port
  input  logic                  i_if_req,
  input  logic [ADDR_W-1:0]     i_if_addr,
  output logic                  o_if_gnt,
  output logic                  o_if_rvalid,
  output logic [DATA_W-1:0]     o_if_rdata,
  // data port
  input  logic                  i_dm_req,
  input  logic                  i_dm_we,
  input  logic [DATA_W/8-1:0]   i_dm_be,
  input  logic [ADDR_W-1:0]     i_dm_addr,
  input  logic [DATA_W-1:0]     i_dm_wdata,
  output logic                  o_dm_gnt,
  output logic                  o_dm_rvalid,
  output logic [DATA_W-1:0]     o_dm_rdata,
  // memory bus
  output logic                  o_bus_req,
  output logic                  o_bus_we,
  output logic [DATA_W/8-1:0]   o_bus_be,
  output logic [ADDR_W-1:0]     o_bus_addr,
  output logic [DATA_W-1:0]     o_bus_wdata,
  input  logic                  i_bus_gnt,
  input  logic                  i_bus_rvalid,
  input  logic [DATA_W-1:0]     i_bus_rdata,
  // pipeline / status
  output logic                  o_bus_stallM,
  output logic                  o_proto_err
);

  localparam int unsigned BE_W = DATA_W / 8;

  bus_state_e state_q;
  bus_state_e state_d;
  bus_owner_e owner_q;
  bus_owner_e owner_d;
  logic       proto_err_q;
  logic       proto_err_d;

  logic       w_decide;
  logic       w_owner_req;
  bus_owner_e w_winner;

  riscv_bus_prio #(
    .STARVE_MAX (STARVE_MAX)
  ) u_prio (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_if_req (i_if_req),
    .i_dm_req (i_dm_req),
    .i_decide (w_decide),
    .o_winner (w_winner)
  );

  // The owner keeps the bus only while it still asserts its request
  assign w_owner_req = (owner_q == OWN_IF) ? i_if_req : i_dm_req;

  // Next-state and output decode of the arbitration FSM
  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    w_decide    = 1'b0;
    proto_err_d = proto_err_q | (i_bus_rvalid && (state_q != RESP));

    o_if_gnt    = 1'b0;
    o_if_rvalid = 1'b0;
    o_if_rdata  = '0;
    o_dm_gnt    = 1'b0;
    o_dm_rvalid = 1'b0;
    o_dm_rdata  = '0;
    o_bus_req   = 1'b0;
    o_bus_we    = 1'b0;
    o_bus_be    = '0;
    o_bus_addr  = '0;
    o_bus_wdata = '0;

    case (state_q)
      IDLE: begin
        if (i_if_req || i_dm_req) begin
          w_decide = 1'b1;
          owner_d  = w_winner;
          state_d  = REQ;
        end
      end

      REQ: begin
        o_bus_req = w_owner_req;
        if (owner_q == OWN_IF) begin
          o_bus_we    = 1'b0;
          o_bus_be    = {BE_W{1'b1}};
          o_bus_addr  = i_if_addr;
          o_bus_wdata = '0;
        end else begin
          o_bus_we    = i_dm_we;
          o_bus_be    = i_dm_be;
          o_bus_addr  = i_dm_addr;
          o_bus_wdata = i_dm_wdata;
        end
        // A withdrawn request beats a same-cycle bus grant
        if (!w_owner_req) begin
          state_d = IDLE;
        end else if (i_bus_gnt) begin
          o_if_gnt = (owner_q == OWN_IF);
          o_dm_gnt = (owner_q == OWN_DM);
          state_d  = RESP;
        end
      end

      RESP: begin
        if (i_bus_rvalid) begin
          if (owner_q == OWN_IF) begin
            o_if_rvalid = 1'b1;
            o_if_rdata  = i_bus_rdata;
          end else begin
            o_dm_rvalid = 1'b1;
            o_dm_rdata  = i_bus_rdata;
          end
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // MEM stalls until its response is back; forced low while in reset
  assign o_bus_stallM = rst_n & i_dm_req & ~o_dm_rvalid;
  assign o_proto_err  = proto_err_q;

  // FSM state, owner and sticky error registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      owner_q     <= OWN_IF;
      proto_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      proto_err_q <= proto_err_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_riscv_bus_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_riscv_bus_arbiter
//  Description : Directed, table-driven bench for riscv_bus_arbiter with
//                hand-written sequences for starvation and reset corners.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_riscv_bus_arbiter;
  import riscv_bus_pkg::*;

  localparam int ADDR_W     = 32;
  localparam int DATA_W     = 32;
  localparam int BE_W       = DATA_W / 8;
  localparam int STARVE_MAX = 4;

  localparam logic [31:0] A_IF  = 32'h0000_0100;
  localparam logic [31:0] A_DM  = 32'h0000_0200;
  localparam logic [31:0] A_DM2 = 32'h0000_0300;
  localparam logic [31:0] WDATA = 32'hCAFE_F00D;

  // expected-flag bits: {if_gnt, if_rvalid, dm_gnt, dm_rvalid, bus_req, bus_we, stallM}
  localparam logic [6:0] IFG  = 7'b1000000;
  localparam logic [6:0] IFV  = 7'b0100000;
  localparam logic [6:0] DMG  = 7'b0010000;
  localparam logic [6:0] DMV  = 7'b0001000;
  localparam logic [6:0] BREQ = 7'b0000100;
  localparam logic [6:0] BWE  = 7'b0000010;
  localparam logic [6:0] STL  = 7'b0000001;
  localparam logic [6:0] NONE = 7'b0000000;

  logic                clk = 1'b0;
  logic                rst_n = 1'b0;
  logic                if_req = 1'b0;
  logic [ADDR_W-1:0]   if_addr = A_IF;
  logic                if_gnt, if_rvalid;
  logic [DATA_W-1:0]   if_rdata;
  logic                dm_req = 1'b0;
  logic                dm_we = 1'b0;
  logic [BE_W-1:0]     dm_be = '0;
  logic [ADDR_W-1:0]   dm_addr = '0;
  logic [DATA_W-1:0]   dm_wdata = WDATA;
  logic                dm_gnt, dm_rvalid;
  logic [DATA_W-1:0]   dm_rdata;
  logic                bus_req, bus_we;
  logic [BE_W-1:0]     bus_be;
  logic [ADDR_W-1:0]   bus_addr;
  logic [DATA_W-1:0]   bus_wdata;
  logic                bus_gnt = 1'b0;
  logic                bus_rvalid = 1'b0;
  logic [DATA_W-1:0]   bus_rdata = '0;
  logic                bus_stallM, proto_err;

  always #5 clk = ~clk;

  riscv_bus_arbiter #(
    .ADDR_W     (ADDR_W),
    .DATA_W     (DATA_W),
    .STARVE_MAX (STARVE_MAX)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_if_req     (if_req),
    .i_if_addr    (if_addr),
    .o_if_gnt     (if_gnt),
    .o_if_rvalid  (if_rvalid),
    .o_if_rdata   (if_rdata),
    .i_dm_req     (dm_req),
    .i_dm_we      (dm_we),
    .i_dm_be      (dm_be),
    .i_dm_addr    (dm_addr),
    .i_dm_wdata   (dm_wdata),
    .o_dm_gnt     (dm_gnt),
    .o_dm_rvalid  (dm_rvalid),
    .o_dm_rdata   (dm_rdata),
    .o_bus_req    (bus_req),
    .o_bus_we     (bus_we),
    .o_bus_be     (bus_be),
    .o_bus_addr   (bus_addr),
    .o_bus_wdata  (bus_wdata),
    .i_bus_gnt    (bus_gnt),
    .i_bus_rvalid (bus_rvalid),
    .i_bus_rdata  (bus_rdata),
    .o_bus_stallM (bus_stallM),
    .o_proto_err  (proto_err)
  );

  typedef struct {
    logic        if_req;
    logic        dm_req;
    logic        dm_we;
    logic [3:0]  dm_be;
    logic [31:0] dm_addr;
    logic        bus_gnt;
    logic        bus_rvalid;
    logic [31:0] bus_rdata;
    logic [6:0]  exp_flags;
    logic [31:0] exp_rdata;
    logic [31:0] exp_addr;
    logic [3:0]  exp_be;
  } vec_t;

  vec_t vecs[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  function automatic void add(input logic ir, input logic dr, input logic dw,
                              input logic [3:0] dbe, input logic [31:0] da,
                              input logic g, input logic rv, input logic [31:0] rd,
                              input logic [6:0] ef, input logic [31:0] erd,
                              input logic [31:0] ea, input logic [3:0] ebe);
    vec_t v;
    v.if_req = ir;  v.dm_req = dr;  v.dm_we = dw;  v.dm_be = dbe;  v.dm_addr = da;
    v.bus_gnt = g;  v.bus_rvalid = rv;  v.bus_rdata = rd;
    v.exp_flags = ef;  v.exp_rdata = erd;  v.exp_addr = ea;  v.exp_be = ebe;
    vecs.push_back(v);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    if_req     = v.if_req;
    dm_req     = v.dm_req;
    dm_we      = v.dm_we;
    dm_be      = v.dm_be;
    dm_addr    = v.dm_addr;
    bus_gnt    = v.bus_gnt;
    bus_rvalid = v.bus_rvalid;
    bus_rdata  = v.bus_rdata;
  endtask

  task automatic check_vec(input int i, input vec_t v);
    logic [6:0] f;
    f = v.exp_flags;
    check($sformatf("v%0d if_gnt", i),    32'(if_gnt),     32'(f[6]));
    check($sformatf("v%0d if_rvalid", i), 32'(if_rvalid),  32'(f[5]));
    check($sformatf("v%0d dm_gnt", i),    32'(dm_gnt),     32'(f[4]));
    check($sformatf("v%0d dm_rvalid", i), 32'(dm_rvalid),  32'(f[3]));
    check($sformatf("v%0d bus_req", i),   32'(bus_req),    32'(f[2]));
    check($sformatf("v%0d stallM", i),    32'(bus_stallM), 32'(f[0]));
    check($sformatf("v%0d proto_err", i), 32'(proto_err),  32'd0);
    check($sformatf("v%0d if_rdata", i),  if_rdata, f[5] ? v.exp_rdata : 32'd0);
    check($sformatf("v%0d dm_rdata", i),  dm_rdata, f[3] ? v.exp_rdata : 32'd0);
    if (f[2]) begin
      check($sformatf("v%0d bus_we", i),   32'(bus_we), 32'(f[1]));
      check($sformatf("v%0d bus_addr", i), bus_addr,    v.exp_addr);
      check($sformatf("v%0d bus_be", i),   32'(bus_be), 32'(v.exp_be));
      if (f[1]) check($sformatf("v%0d bus_wdata", i), bus_wdata, WDATA);
    end
  endtask

  logic [1:0] starve_exp [6];

  initial begin
    // ---- fetch only, 0x100, gnt at cycle 1, rvalid at cycle 2
    add(1,0,0,4'h0,32'h0, 0,0,32'h0,           NONE,        32'h0,          32'h0, 4'h0);
    add(1,0,0,4'h0,32'h0, 1,0,32'h0,           IFG|BREQ,    32'h0,          A_IF,  4'hF);
    add(0,0,0,4'h0,32'h0, 0,1,32'hDEAD_BEEF,   IFV,         32'hDEAD_BEEF,  32'h0, 4'h0);
    add(0,0,0,4'h0,32'h0, 0,0,32'h0,           NONE,        32'h0,          32'h0, 4'h0);
    // ---- both requesting: data write to 0x200 be=0011 first, then fetch
    add(1,1,1,4'h3,A_DM,  0,0,32'h0,           STL,         32'h0,          32'h0, 4'h0);
    add(1,1,1,4'h3,A_DM,  1,0,32'h0,           DMG|BREQ|BWE|STL, 32'h0,     A_DM,  4'h3);
    add(1,1,1,4'h3,A_DM,  0,1,32'h0,           DMV,         32'h0,          32'h0, 4'h0);
    add(1,0,0,4'h0,32'h0, 0,0,32'h0,           NONE,        32'h0,          32'h0, 4'h0);
    add(1,0,0,4'h0,32'h0, 1,0,32'h0,           IFG|BREQ,    32'h0,          A_IF,  4'hF);
    add(0,0,0,4'h0,32'h0, 0,1,32'hA5A5_0001,   IFV,         32'hA5A5_0001,  32'h0, 4'h0);
    // ---- data read, rvalid 5 cycles after gnt; bus rdata garbage while waiting
    add(0,1,0,4'hF,A_DM2, 0,0,32'h0,           STL,         32'h0,          32'h0, 4'h0);
    add(0,1,0,4'hF,A_DM2, 1,0,32'h0,           DMG|BREQ|STL,32'h0,          A_DM2, 4'hF);
    for (int k = 0; k < 4; k++)
      add(0,1,0,4'hF,A_DM2, 0,0,32'h7777_7777, STL,         32'h0,          32'h0, 4'h0);
    add(0,1,0,4'hF,A_DM2, 0,1,32'h1234_5678,   DMV,         32'h1234_5678,  32'h0, 4'h0);
    // ---- fetch withdraws in REQ together with a bus gnt, then a data read proves IDLE
    add(1,0,0,4'h0,32'h0, 0,0,32'h0,           NONE,        32'h0,          32'h0, 4'h0);
    add(1,0,0,4'h0,32'h0, 0,0,32'h0,           BREQ,        32'h0,          A_IF,  4'hF);
    add(0,0,0,4'h0,32'h0, 1,0,32'h0,           NONE,        32'h0,          32'h0, 4'h0);
    add(0,1,0,4'hF,A_DM,  0,0,32'h0,           STL,         32'h0,          32'h0, 4'h0);
    add(0,1,0,4'hF,A_DM,  1,0,32'h0,           DMG|BREQ|STL,32'h0,          A_DM,  4'hF);
    add(0,1,0,4'hF,A_DM,  0,1,32'hCAFE_0002,   DMV,         32'hCAFE_0002,  32'h0, 4'h0);
    add(0,0,0,4'h0,32'h0, 0,0,32'h0,           NONE,        32'h0,          32'h0, 4'h0);

    // ---- reset state: outputs 0 even with requests present
    if_req = 1'b1;
    dm_req = 1'b1;
    repeat (2) @(negedge clk);
    #2;
    check("rst bus_req", 32'(bus_req),    32'd0);
    check("rst if_gnt",  32'(if_gnt),     32'd0);
    check("rst dm_gnt",  32'(dm_gnt),     32'd0);
    check("rst stallM",  32'(bus_stallM), 32'd0);
    check("rst perr",    32'(proto_err),  32'd0);
    if_req = 1'b0;
    dm_req = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;

    // ---- cycle-by-cycle vector table
    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i]);
      #2;
      check_vec(i, vecs[i]);
      @(negedge clk);
    end

    // ---- starvation: both held, expected grant order DM DM DM DM IF DM
    starve_exp[0] = 2'b01; starve_exp[1] = 2'b01; starve_exp[2] = 2'b01;
    starve_exp[3] = 2'b01; starve_exp[4] = 2'b10; starve_exp[5] = 2'b01;
    if_req = 1'b1; dm_req = 1'b1; dm_we = 1'b0; dm_be = 4'hF; dm_addr = A_DM;
    bus_gnt = 1'b0; bus_rvalid = 1'b0; bus_rdata = '0;
    for (int t = 0; t < 6; t++) begin
      @(negedge clk);               // IDLE -> REQ
      bus_gnt = 1'b1;
      #2;
      check($sformatf("starve grant %0d {if,dm}", t), 32'({if_gnt, dm_gnt}), 32'(starve_exp[t]));
      @(negedge clk);               // REQ -> RESP
      bus_gnt = 1'b0;
      bus_rvalid = 1'b1;
      @(negedge clk);               // RESP -> IDLE
      bus_rvalid = 1'b0;
    end
    if_req = 1'b0;
    dm_req = 1'b0;
    @(negedge clk);

    // ---- reset asserted in RESP, late rvalid afterwards
    dm_req = 1'b1; dm_we = 1'b0; dm_addr = A_DM2;
    @(negedge clk);                 // REQ
    bus_gnt = 1'b1;
    @(negedge clk);                 // RESP
    bus_gnt = 1'b0;
    rst_n = 1'b0;
    #2;
    check("midrst dm_rvalid", 32'(dm_rvalid),  32'd0);
    check("midrst stallM",    32'(bus_stallM), 32'd0);
    check("midrst bus_req",   32'(bus_req),    32'd0);
    check("midrst perr",      32'(proto_err),  32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    dm_req = 1'b0;
    @(negedge clk);
    bus_rvalid = 1'b1;
    bus_rdata  = 32'hBAD0_BAD0;
    #2;
    check("late dm_rvalid", 32'(dm_rvalid), 32'd0);
    check("late if_rvalid", 32'(if_rvalid), 32'd0);
    check("late dm_rdata",  dm_rdata,       32'd0);
    @(negedge clk);
    bus_rvalid = 1'b0;
    #2;
    check("late perr set", 32'(proto_err), 32'd1);
    repeat (3) @(negedge clk);
    #2;
    check("perr sticky", 32'(proto_err), 32'd1);
    rst_n = 1'b0;
    #2;
    check("perr cleared", 32'(proto_err), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/riscv_bus_arbiter.md
Name: riscv_bus_arbiter

Overview:
Shares the single memory bus between two requesters: the fetch stage (F) and the data/MEM stage (M).
- Serialises transactions with one outstanding access at a time.
- Routes grants and responses back to the owning requester.
- Generates o_bus_stallM, the bus-stall input consumed by the pipeline hazard unit.
- Data wins by default. A starvation counter guarantees fetch forward progress.

Parameters:
ADDR_W, 32, address width.
DATA_W, 32, data width; byte-enable width is DATA_W/8.
STARVE_MAX, 4, number of consecutive data grants, taken while fetch is waiting, after which fetch gets priority once. Range 1..15.

Ports:
clk  in  1  clock.
rst_n  in  1  reset, asynchronous, active-low.
i_if_req  in  1  fetch read request; held until o_if_gnt, may be withdrawn (flush).
i_if_addr  in  ADDR_W  fetch address.
o_if_gnt  out  1  fetch request accepted by bus.
o_if_rvalid  out  1  fetch read data valid.
o_if_rdata  out  DATA_W  fetch read data.
i_dm_req  in  1  data request; held stable until o_dm_rvalid, never withdrawn.
i_dm_we  in  1  1 = write.
i_dm_be  in  DATA_W/8  byte enables.
i_dm_addr  in  ADDR_W  data address.
i_dm_wdata  in  DATA_W  write data.
o_dm_gnt  out  1  data request accepted.
o_dm_rvalid  out  1  data response (read data or write ack).
o_dm_rdata  out  DATA_W  data read data.
o_bus_req  out  1  bus request.
o_bus_we  out  1  bus write.
o_bus_be  out  DATA_W/8  bus byte enables.
o_bus_addr  out  ADDR_W  bus address.
o_bus_wdata  out  DATA_W  bus write data.
i_bus_gnt  in  1  bus accepts request (valid only while o_bus_req).
i_bus_rvalid  in  1  bus response (reads and writes).
i_bus_rdata  in  DATA_W  bus read data.
o_bus_stallM  out  1  MEM stage must stall.
o_proto_err  out  1  sticky: response received outside RESP state.

Behaviour:
- States: IDLE, REQ, RESP. Registered owner: OWN_IF or OWN_DM. Registered starve counter is 4 bits.
- Reset: state IDLE, owner OWN_IF, counter 0, o_proto_err 0. All outputs are 0 during reset; all outputs except o_proto_err are combinational decodes of state and inputs.
- Reset mid-transaction: return to IDLE immediately. A late i_bus_rvalid then sets o_proto_err and is not forwarded.
- IDLE arbitration:
  - Fetch wins if i_if_req && (!i_dm_req || counter == STARVE_MAX). Otherwise data wins if i_dm_req.
  - The winner is latched as owner; next state is REQ. With no request, stay in IDLE.
- Counter update, on each IDLE decision:
  - Data granted while i_if_req is high: counter + 1, saturating at STARVE_MAX.
  - Fetch granted, or i_if_req low: counter cleared to 0.
- REQ:
  - o_bus_req = owner's request. Bus fields are muxed from the owner's inputs; fetch drives we=0, be all-ones, wdata 0.
  - i_bus_gnt && o_bus_req: owner's gnt pulses the same cycle; next state RESP.
  - Owner OWN_IF and i_if_req low (withdrawn): o_bus_req=0; next state IDLE; no gnt.
- RESP:
  - o_bus_req=0.
  - i_bus_rvalid: owner's rvalid pulses the same cycle with rdata = i_bus_rdata; next state IDLE.
  - The non-owner's rvalid is never asserted.
- Latency: request seen in IDLE at cycle 0 → bus request at cycle 1 → gnt at cycle ≥1 → rvalid at cycle ≥2 → IDLE at cycle ≥3. Minimum 3 cycles per transaction.
- o_bus_stallM = i_dm_req && !o_dm_rvalid (combinational). It deasserts in the cycle the response returns.
- Simultaneous fetch withdrawal and i_bus_gnt in REQ: the withdrawal wins (o_bus_req already low, so the gnt is ignored).
- i_bus_rvalid in IDLE or REQ: sets o_proto_err (cleared only by reset) and is dropped.
- o_if_rdata and o_dm_rdata are 0 when their respective rvalid is low.

Decomposition:
- Package riscv_bus_pkg holds:
  - enum bus_state_e {IDLE, REQ, RESP}
  - enum bus_owner_e {OWN_IF, OWN_DM}
  - localparams for default ADDR_W and DATA_W
- Sub-module riscv_bus_prio: the starve counter plus winner selection.
  - Inputs: if_req, dm_req, decide strobe.
  - Output: winner.

Test Plan:
- Fetch only, address 0x100; bus gnt at cycle 1, rvalid at cycle 2 with 0xDEADBEEF → o_if_gnt at cycle 1, o_if_rvalid at cycle 2 with 0xDEADBEEF; o_bus_stallM stays 0.
- Fetch and data both requesting in IDLE; data is a write to 0x200, be=4'b0011 → data owns first; o_bus_we=1, be=0011; o_bus_stallM high until o_dm_rvalid, then fetch is served.
- Data held continuously with fetch pending, STARVE_MAX=4 → grant order DM, DM, DM, DM, IF, DM; counter resets after the IF grant.
- Fetch owner in REQ, bus withholds gnt, i_if_req drops → o_bus_req=0 the same cycle, state returns to IDLE, no o_if_gnt or o_if_rvalid.
- Reset asserted in RESP, then i_bus_rvalid pulses after release → no rvalid forwarded; o_proto_err=1 until the next reset.
- Bus rvalid 5 cycles after gnt on a data read → o_bus_stallM high for all wait cycles; o_dm_rdata is 0 until the rvalid cycle.
